// File: rtl/raster_sched.sv
// raster_sched: 640x480 pixel-core sequencer (CLR/CMP per pixel, 2 clk cadence) with a 4-slot polygon bank.
// Latency: all outputs registered; writes reach the bank 1 clk after acceptance. Backpressure: poly_wr_ready low only in a swap cycle.
// RASTER_SCHED_SHADOW_EN selects a shadow bank swapped at frame boundaries; undefined, writes go straight to the active bank.
module raster_sched #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic        poly_wr_valid,
    output logic        poly_wr_ready,
    input  logic [1:0]  poly_wr_slot,
    input  logic        poly_wr_en,
    input  logic [50:0] poly_wr_data,
    input  logic        commit_req,
    output logic        commit_pending,
    output logic [8:0]  pixel_row,
    output logic [9:0]  pixel_col,
    output logic        pixel_clr,
    output logic        cmp_en,
    output logic [3:0]  en_polygon,
    output logic [50:0] poly_a_data,
    output logic [50:0] poly_b_data,
    output logic [50:0] poly_c_data,
    output logic [50:0] poly_d_data,
    output logic        hsync,
    output logic        vsync,
    output logic        display_en,
    output logic        frame_done
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [15:0] H_LAST = 16'(H_TOTAL - 1);
    localparam logic [15:0] V_LAST = 16'(V_TOTAL - 1);
    localparam logic [15:0] H_ACT  = 16'(H_ACTIVE);
    localparam logic [15:0] V_ACT  = 16'(V_ACTIVE);
    localparam logic [15:0] HS_BEG = 16'(H_ACTIVE + H_FP);
    localparam logic [15:0] HS_END = 16'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [15:0] VS_BEG = 16'(V_ACTIVE + V_FP);
    localparam logic [15:0] VS_END = 16'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {S_IDLE, S_CLR, S_CMP} state_t;

    state_t      r_state, w_state_nxt;
    logic [15:0] r_h, r_v, w_h_nxt, w_v_nxt;
    logic        w_last;

    logic w_clr_nxt, w_cmp_nxt, w_disp_nxt, w_hs_nxt, w_vs_nxt, w_fd_nxt;
    logic r_clr, r_cmp, r_disp, r_hs, r_vs, r_fd;

    logic [50:0] r_act_dat [4];
    logic [3:0]  r_act_en;
    logic        w_wr_acc;

    assign w_last = (r_state == S_CMP) && (r_h == H_LAST) && (r_v == V_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_h     <= '0;
            r_v     <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_h     <= w_h_nxt;
            r_v     <= w_v_nxt;
        end
    end

    // run is only looked at in IDLE and on the last CMP of a frame
    always_comb begin
        w_state_nxt = r_state;
        w_h_nxt     = r_h;
        w_v_nxt     = r_v;
        case (r_state)
            S_IDLE: begin
                w_h_nxt = '0;
                w_v_nxt = '0;
                if (run) w_state_nxt = S_CLR;
            end
            S_CLR: w_state_nxt = S_CMP;
            S_CMP: begin
                if (w_last) begin
                    w_h_nxt     = '0;
                    w_v_nxt     = '0;
                    w_state_nxt = run ? S_CLR : S_IDLE;
                end else begin
                    w_state_nxt = S_CLR;
                    if (r_h == H_LAST) begin
                        w_h_nxt = '0;
                        w_v_nxt = r_v + 16'd1;
                    end else begin
                        w_h_nxt = r_h + 16'd1;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_h_nxt     = '0;
                w_v_nxt     = '0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with r_state
    always_comb begin
        w_clr_nxt  = (w_state_nxt == S_CLR);
        w_disp_nxt = (w_state_nxt != S_IDLE) && (w_h_nxt < H_ACT) && (w_v_nxt < V_ACT);
        w_cmp_nxt  = (w_state_nxt == S_CMP) && w_disp_nxt;
        w_hs_nxt   = !((w_state_nxt != S_IDLE) && (w_h_nxt >= HS_BEG) && (w_h_nxt < HS_END));
        w_vs_nxt   = !((w_state_nxt != S_IDLE) && (w_v_nxt >= VS_BEG) && (w_v_nxt < VS_END));
        w_fd_nxt   = (w_state_nxt == S_CMP) && (w_h_nxt == H_LAST) && (w_v_nxt == V_LAST);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr  <= 1'b0;
            r_cmp  <= 1'b0;
            r_disp <= 1'b0;
            r_hs   <= 1'b1;
            r_vs   <= 1'b1;
            r_fd   <= 1'b0;
        end else begin
            r_clr  <= w_clr_nxt;
            r_cmp  <= w_cmp_nxt;
            r_disp <= w_disp_nxt;
            r_hs   <= w_hs_nxt;
            r_vs   <= w_vs_nxt;
            r_fd   <= w_fd_nxt;
        end
    end

`ifdef RASTER_SCHED_SHADOW_EN
    logic [50:0] r_sh_dat [4];
    logic [3:0]  r_sh_en;
    logic        r_pend, r_rdy;
    logic        w_swap, w_pend_nxt, w_rdy_nxt;

    // r_fd is high exactly in the last CMP cycle of the frame
    assign w_swap     = r_pend & ((r_state == S_IDLE) | r_fd);
    assign w_pend_nxt = commit_req | (r_pend & ~w_swap);
    assign w_rdy_nxt  = ~(w_pend_nxt & ((w_state_nxt == S_IDLE) | w_fd_nxt));
    assign w_wr_acc   = poly_wr_valid & r_rdy;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                r_sh_dat[i]  <= '0;
                r_act_dat[i] <= '0;
            end
            r_sh_en  <= '0;
            r_act_en <= '0;
            r_pend   <= 1'b0;
            r_rdy    <= 1'b1;
        end else begin
            r_pend <= w_pend_nxt;
            r_rdy  <= w_rdy_nxt;
            if (w_wr_acc) begin
                r_sh_dat[poly_wr_slot] <= poly_wr_data;
                r_sh_en[poly_wr_slot]  <= poly_wr_en;
            end
            if (w_swap) begin
                for (int i = 0; i < 4; i++) r_act_dat[i] <= r_sh_dat[i];
                r_act_en <= r_sh_en;
            end
        end
    end

    assign poly_wr_ready  = r_rdy;
    assign commit_pending = r_pend;
`else
    logic w_unused_commit;

    assign w_unused_commit = commit_req;
    assign w_wr_acc        = poly_wr_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_act_dat[i] <= '0;
            r_act_en <= '0;
        end else if (w_wr_acc) begin
            r_act_dat[poly_wr_slot] <= poly_wr_data;
            r_act_en[poly_wr_slot]  <= poly_wr_en;
        end
    end

    assign poly_wr_ready  = 1'b1;
    assign commit_pending = 1'b0;
`endif

    assign pixel_col   = r_h[9:0];
    assign pixel_row   = r_v[8:0];
    assign pixel_clr   = r_clr;
    assign cmp_en      = r_cmp;
    assign display_en  = r_disp;
    assign hsync       = r_hs;
    assign vsync       = r_vs;
    assign frame_done  = r_fd;
    assign en_polygon  = r_act_en;
    assign poly_a_data = r_act_dat[0];
    assign poly_b_data = r_act_dat[1];
    assign poly_c_data = r_act_dat[2];
    assign poly_d_data = r_act_dat[3];

endmodule

// File: tb/tb_raster_sched.sv
// Directed bench for raster_sched on a reduced 16x8 timing (frame = 256 clk);
// expectations follow RASTER_SCHED_SHADOW_EN the same way the design does.
module tb_raster_sched;

    logic        clk = 1'b0;
    logic        rst, run;
    logic        poly_wr_valid, poly_wr_ready;
    logic [1:0]  poly_wr_slot;
    logic        poly_wr_en;
    logic [50:0] poly_wr_data;
    logic        commit_req, commit_pending;
    logic [8:0]  pixel_row;
    logic [9:0]  pixel_col;
    logic        pixel_clr, cmp_en;
    logic [3:0]  en_polygon;
    logic [50:0] poly_a_data, poly_b_data, poly_c_data, poly_d_data;
    logic        hsync, vsync, display_en, frame_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t_clr0, t_fd1, t_fd2;

    localparam logic [50:0] DC = 51'h1_2345_6789_ABCD;
    localparam logic [50:0] DA = 51'h5_5555_0000_AAAA;
    localparam logic [50:0] DD = 51'h2_0F0F_F0F0_1234;

`ifdef RASTER_SCHED_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    raster_sched #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut (
        .clk(clk), .rst(rst), .run(run),
        .poly_wr_valid(poly_wr_valid), .poly_wr_ready(poly_wr_ready),
        .poly_wr_slot(poly_wr_slot), .poly_wr_en(poly_wr_en), .poly_wr_data(poly_wr_data),
        .commit_req(commit_req), .commit_pending(commit_pending),
        .pixel_row(pixel_row), .pixel_col(pixel_col),
        .pixel_clr(pixel_clr), .cmp_en(cmp_en), .en_polygon(en_polygon),
        .poly_a_data(poly_a_data), .poly_b_data(poly_b_data),
        .poly_c_data(poly_c_data), .poly_d_data(poly_d_data),
        .hsync(hsync), .vsync(vsync), .display_en(display_en), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wait_fd(input string tag);
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 1000) begin
            tick();
            n++;
        end
        check(tag, 64'(frame_done), 64'd1);
    endtask

    task automatic idle_outputs(input string tag);
        check({tag, "_clr"},  64'(pixel_clr),  64'd0);
        check({tag, "_cmp"},  64'(cmp_en),     64'd0);
        check({tag, "_col"},  64'(pixel_col),  64'd0);
        check({tag, "_row"},  64'(pixel_row),  64'd0);
        check({tag, "_disp"}, 64'(display_en), 64'd0);
        check({tag, "_hs"},   64'(hsync),      64'd1);
        check({tag, "_vs"},   64'(vsync),      64'd1);
        check({tag, "_fd"},   64'(frame_done), 64'd0);
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; commit_req = 1'b0;
        poly_wr_valid = 1'b0; poly_wr_slot = 2'd0; poly_wr_en = 1'b0; poly_wr_data = '0;

        ticks(3);
        idle_outputs("rst");
        check("rst_en",   64'(en_polygon),     64'd0);
        check("rst_a",    64'(poly_a_data),    64'd0);
        check("rst_d",    64'(poly_d_data),    64'd0);
        check("rst_pend", 64'(commit_pending), 64'd0);
        check("rst_rdy",  64'(poly_wr_ready),  64'd1);

        rst = 1'b0;
        ticks(100);
        idle_outputs("idle");
        check("idle_rdy", 64'(poly_wr_ready), 64'd1);

        // first CLR one clock after run is sampled
        run = 1'b1;
        tick(); t_clr0 = cyc;
        check("clr0_clr",  64'(pixel_clr),  64'd1);
        check("clr0_cmp",  64'(cmp_en),     64'd0);
        check("clr0_col",  64'(pixel_col),  64'd0);
        check("clr0_disp", 64'(display_en), 64'd1);
        check("clr0_hs",   64'(hsync),      64'd1);
        tick();
        check("cmp0_clr", 64'(pixel_clr), 64'd0);
        check("cmp0_cmp", 64'(cmp_en),    64'd1);
        check("cmp0_col", 64'(pixel_col), 64'd0);

        ticks(19);
        check("h10_col",  64'(pixel_col),  64'd10);
        check("h10_clr",  64'(pixel_clr),  64'd1);
        check("h10_hs",   64'(hsync),      64'd0);
        check("h10_disp", 64'(display_en), 64'd0);
        tick();
        check("h10_cmp",   64'(cmp_en), 64'd0);
        check("h10_hs_b",  64'(hsync),  64'd0);
        ticks(5);
        check("h13_col", 64'(pixel_col), 64'd13);
        check("h13_hs",  64'(hsync),     64'd1);

        ticks(134);
        check("v5_row", 64'(pixel_row), 64'd5);
        check("v5_col", 64'(pixel_col), 64'd0);
        check("v5_vs",  64'(vsync),     64'd0);
        ticks(64);
        check("v7_row", 64'(pixel_row), 64'd7);
        check("v7_vs",  64'(vsync),     64'd1);

        wait_fd("fd1");
        t_fd1 = cyc;
        check("fd1_time", 64'(t_fd1 - t_clr0), 64'd255);
        check("fd1_col",  64'(pixel_col),      64'd15);
        check("fd1_row",  64'(pixel_row),      64'd7);
        tick();
        check("f2_clr", 64'(pixel_clr),  64'd1);
        check("f2_col", 64'(pixel_col),  64'd0);
        check("f2_row", 64'(pixel_row),  64'd0);
        check("f2_fd",  64'(frame_done), 64'd0);

        // mid-frame write to slot 2 with a commit request
        ticks(3);
        poly_wr_valid = 1'b1; poly_wr_slot = 2'd2; poly_wr_en = 1'b1; poly_wr_data = DC;
        commit_req = 1'b1;
        tick();
        poly_wr_valid = 1'b0; commit_req = 1'b0;
        check("wr_pend", 64'(commit_pending), SHADOW ? 64'd1 : 64'd0);
        check("wr_en",   64'(en_polygon),     SHADOW ? 64'd0 : 64'h4);
        check("wr_c",    64'(poly_c_data),    SHADOW ? 64'd0 : 64'(DC));

        wait_fd("fd2");
        t_fd2 = cyc;
        check("fd_period", 64'(t_fd2 - t_fd1), 64'd256);
        check("swap_pend", 64'(commit_pending), SHADOW ? 64'd1 : 64'd0);
        check("swap_rdy",  64'(poly_wr_ready),  SHADOW ? 64'd0 : 64'd1);
        check("swap_en",   64'(en_polygon),     SHADOW ? 64'd0 : 64'h4);

        // collision: write and commit_req in the swap cycle
        poly_wr_valid = 1'b1; poly_wr_slot = 2'd0; poly_wr_en = 1'b1; poly_wr_data = DA;
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        check("col_clr",  64'(pixel_clr),      64'd1);
        check("col_en",   64'(en_polygon),     SHADOW ? 64'h4 : 64'h5);
        check("col_c",    64'(poly_c_data),    64'(DC));
        check("col_a",    64'(poly_a_data),    SHADOW ? 64'd0 : 64'(DA));
        check("col_pend", 64'(commit_pending), SHADOW ? 64'd1 : 64'd0);
        check("col_rdy",  64'(poly_wr_ready),  64'd1);
        tick();
        poly_wr_valid = 1'b0;
        check("col2_pend", 64'(commit_pending), SHADOW ? 64'd1 : 64'd0);
        check("col2_a",    64'(poly_a_data),    SHADOW ? 64'd0 : 64'(DA));

        // drop run mid-frame: scan finishes the frame, then idles
        ticks(6);
        run = 1'b0;
        wait_fd("fd3");
        check("fd3_period", 64'(cyc - t_fd2), 64'd256);
        tick();
        idle_outputs("stop");
        check("stop_a",    64'(poly_a_data),    64'(DA));
        check("stop_en",   64'(en_polygon),     64'h5);
        check("stop_pend", 64'(commit_pending), 64'd0);
        ticks(5);
        check("stop2_clr", 64'(pixel_clr), 64'd0);

        // commit while idle swaps on the following cycle
        poly_wr_valid = 1'b1; poly_wr_slot = 2'd3; poly_wr_en = 1'b1; poly_wr_data = DD;
        commit_req = 1'b1;
        tick();
        poly_wr_valid = 1'b0; commit_req = 1'b0;
        check("iw_pend", 64'(commit_pending), SHADOW ? 64'd1 : 64'd0);
        check("iw_rdy",  64'(poly_wr_ready),  SHADOW ? 64'd0 : 64'd1);
        check("iw_d",    64'(poly_d_data),    SHADOW ? 64'd0 : 64'(DD));
        tick();
        check("is_d",    64'(poly_d_data),    64'(DD));
        check("is_en",   64'(en_polygon),     64'hD);
        check("is_pend", 64'(commit_pending), 64'd0);
        check("is_rdy",  64'(poly_wr_ready),  64'd1);

        // reset mid-frame aborts at once and clears the banks
        run = 1'b1;
        ticks(10);
        rst = 1'b1;
        #1;
        idle_outputs("abort");
        check("abort_en",   64'(en_polygon),     64'd0);
        check("abort_a",    64'(poly_a_data),    64'd0);
        check("abort_c",    64'(poly_c_data),    64'd0);
        check("abort_pend", 64'(commit_pending), 64'd0);
        check("abort_rdy",  64'(poly_wr_ready),  64'd1);
        #2;
        rst = 1'b0;
        run = 1'b0;
        ticks(3);
        check("post_clr", 64'(pixel_clr),  64'd0);
        check("post_en",  64'(en_polygon), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
